line_fetcher: RTL and testbench

- Per-scanline SDRAM prefetch stage between sdram_burst port 0 (read side) and the background/mask image_fifo pair.
- On each hblank rising edge, computes the next visible line's word address and issues read bursts until exactly 3*PIXELS_PER_LINE words are received.
- Each 16-bit word carries one background byte (low) and one mask byte (high). Bytes are packed into 24-bit pixels and written to both FIFOs.

---
 rtl/line_fetcher.sv | 197 +++++++++++++++++++
 tb/tb_line_fetcher.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_fetcher.sv
// Per-scanline SDRAM prefetch: fetches 3 words per pixel into the background/mask FIFO pair.
// Optional build macro LINE_FETCH_STATS_EN adds the short_lines and bursts_per_line counters.
module line_fetcher #(
    parameter int unsigned PIXELS_PER_LINE = 720,
    parameter int unsigned LINES           = 720
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        hblank,
    input  logic [9:0]  video_y,
    output logic [24:0] sd_addr,
    output logic        sd_rd,
    output logic        sd_end_burst,
    input  logic        sd_data_available,
    input  logic [15:0] sd_q,
    output logic        fifo_clear,
    output logic        fifo_wr,
    output logic [23:0] bg_data,
    output logic [23:0] mask_data,
    output logic        line_done
`ifdef LINE_FETCH_STATS_EN
    ,
    output logic [15:0] short_lines,
    output logic [7:0]  bursts_per_line
`endif
);

    localparam int unsigned WORDS = 3 * PIXELS_PER_LINE;
    localparam int unsigned WCW   = $clog2(WORDS + 1);

    localparam logic [WCW-1:0] WORDS_M1  = WCW'(WORDS - 1);
    localparam logic [WCW-1:0] WORDS_M2  = WCW'(WORDS - 2);
    localparam logic [24:0]    WORDS_25  = 25'(WORDS);
    localparam logic [9:0]     LAST_LINE = 10'(LINES - 1);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StFlush  = 3'd1;
    localparam logic [2:0] StReq    = 3'd2;
    localparam logic [2:0] StStream = 3'd3;
    localparam logic [2:0] StGap    = 3'd4;
    localparam logic [2:0] StDone   = 3'd5;

    logic [2:0]     state_q, state_d;
    logic           hblank_q;
    logic           avail_q;
    logic [WCW-1:0] word_count_q, word_count_d;
    logic [1:0]     byte_phase_q, byte_phase_d;
    logic [24:0]    base_q, base_d;
    logic [24:0]    sd_addr_q, sd_addr_d;
    logic           sd_rd_q, sd_rd_d;
    logic           end_burst_q, end_burst_d;
    logic           fifo_clear_q, fifo_clear_d;
    logic           fifo_wr_q, fifo_wr_d;
    logic [23:0]    bg_q, bg_d;
    logic [23:0]    mask_q, mask_d;
    logic           line_done_q, line_done_d;
    logic [9:0]     next_line;
    logic           line_start;

    assign line_start = hblank & ~hblank_q;

    always_comb begin
        state_d      = state_q;
        word_count_d = word_count_q;
        byte_phase_d = byte_phase_q;
        base_d       = base_q;
        bg_d         = bg_q;
        mask_d       = mask_q;
        line_done_d  = line_done_q;
        sd_rd_d      = 1'b0;
        end_burst_d  = 1'b0;
        fifo_clear_d = 1'b0;
        fifo_wr_d    = 1'b0;
        next_line    = (video_y >= LAST_LINE) ? 10'd0 : video_y + 10'd1;

        // A line start wins over any beat sampled in the same cycle.
        if (line_start) begin
            fifo_clear_d = 1'b1;
            word_count_d = '0;
            byte_phase_d = 2'd0;
            bg_d         = 24'd0;
            mask_d       = 24'd0;
            line_done_d  = 1'b0;
            base_d       = 25'(next_line) * WORDS_25;
            if (state_q == StStream || state_q == StFlush) begin
                end_burst_d = 1'b1;
                state_d     = StFlush;
            end else begin
                state_d = StReq;
            end
        end else begin
            case (state_q)
                StFlush: begin
                    if (!sd_data_available) state_d = StReq;
                end
                StReq: begin
                    sd_rd_d = 1'b1;
                    state_d = StStream;
                end
                StStream: begin
                    if (sd_data_available) begin
                        bg_d         = {sd_q[7:0], bg_q[23:8]};
                        mask_d       = {sd_q[15:8], mask_q[23:8]};
                        word_count_d = word_count_q + 1'b1;
                        end_burst_d  = (word_count_q >= WORDS_M2);
                        if (byte_phase_q == 2'd2) begin
                            byte_phase_d = 2'd0;
                            fifo_wr_d    = 1'b1;
                        end else begin
                            byte_phase_d = byte_phase_q + 2'd1;
                        end
                        if (word_count_q == WORDS_M1) begin
                            state_d     = StDone;
                            line_done_d = 1'b1;
                        end
                    end else if (avail_q) begin
                        state_d = StGap;
                    end
                end
                StGap:   state_d = StReq;
                default: ;
            endcase
        end

        sd_addr_d = base_d + 25'(word_count_d);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            hblank_q     <= 1'b0;
            avail_q      <= 1'b0;
            word_count_q <= '0;
            byte_phase_q <= 2'd0;
            base_q       <= 25'd0;
            sd_addr_q    <= 25'd0;
            sd_rd_q      <= 1'b0;
            end_burst_q  <= 1'b0;
            fifo_clear_q <= 1'b0;
            fifo_wr_q    <= 1'b0;
            bg_q         <= 24'd0;
            mask_q       <= 24'd0;
            line_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            hblank_q     <= hblank;
            avail_q      <= sd_data_available;
            word_count_q <= word_count_d;
            byte_phase_q <= byte_phase_d;
            base_q       <= base_d;
            sd_addr_q    <= sd_addr_d;
            sd_rd_q      <= sd_rd_d;
            end_burst_q  <= end_burst_d;
            fifo_clear_q <= fifo_clear_d;
            fifo_wr_q    <= fifo_wr_d;
            bg_q         <= bg_d;
            mask_q       <= mask_d;
            line_done_q  <= line_done_d;
        end
    end

    assign sd_addr      = sd_addr_q;
    assign sd_rd        = sd_rd_q;
    assign sd_end_burst = end_burst_q;
    assign fifo_clear   = fifo_clear_q;
    assign fifo_wr      = fifo_wr_q;
    assign bg_data      = bg_q;
    assign mask_data    = mask_q;
    assign line_done    = line_done_q;

`ifdef LINE_FETCH_STATS_EN
    logic [15:0] short_lines_q;
    logic [7:0]  burst_cnt_q;
    logic [7:0]  bursts_per_line_q;

    // A short line is one abandoned mid-fetch by the next line start.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            short_lines_q     <= 16'd0;
            burst_cnt_q       <= 8'd0;
            bursts_per_line_q <= 8'd0;
        end else if (line_start) begin
            if (!line_done_q && state_q != StIdle && short_lines_q != 16'hFFFF) begin
                short_lines_q <= short_lines_q + 16'd1;
            end
            bursts_per_line_q <= burst_cnt_q;
            burst_cnt_q       <= 8'd0;
        end else if (sd_rd_d && burst_cnt_q != 8'hFF) begin
            burst_cnt_q <= burst_cnt_q + 8'd1;
        end
    end

    assign short_lines     = short_lines_q;
    assign bursts_per_line = bursts_per_line_q;
`endif

endmodule

// File: tb/tb_line_fetcher.sv
// Scoreboard bench for line_fetcher: an SDRAM model pushes expected pixels, a monitor checks writes.
module tb_line_fetcher;

    localparam int unsigned PPL   = 720;
    localparam int unsigned WORDS = 3 * PPL;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        hblank = 1'b0;
    logic [9:0]  video_y = 10'd0;
    logic [24:0] sd_addr;
    logic        sd_rd;
    logic        sd_end_burst;
    logic        sd_data_available = 1'b0;
    logic [15:0] sd_q = 16'd0;
    logic        fifo_clear;
    logic        fifo_wr;
    logic [23:0] bg_data;
    logic [23:0] mask_data;
    logic        line_done;
`ifdef LINE_FETCH_STATS_EN
    logic [15:0] short_lines;
    logic [7:0]  bursts_per_line;
`endif

    always #4 clk = ~clk;

    line_fetcher #(.PIXELS_PER_LINE(PPL), .LINES(720)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .hblank            (hblank),
        .video_y           (video_y),
        .sd_addr           (sd_addr),
        .sd_rd             (sd_rd),
        .sd_end_burst      (sd_end_burst),
        .sd_data_available (sd_data_available),
        .sd_q              (sd_q),
        .fifo_clear        (fifo_clear),
        .fifo_wr           (fifo_wr),
        .bg_data           (bg_data),
        .mask_data         (mask_data),
        .line_done         (line_done)
`ifdef LINE_FETCH_STATS_EN
        ,
        .short_lines       (short_lines),
        .bursts_per_line   (bursts_per_line)
`endif
    );

    logic [47:0] sb_q[$];
    logic [24:0] rd_exp[$];

    // Stimulus-thread controls
    int checks = 0;
    int failures = 0;
    int line_seq = 0;
    int kill_seq = 0;
    int cfg_drop = 0;
    int cfg_trail = 1;
    bit cfg_override = 1'b0;

    // SDRAM model state
    int          m_seq = 0;
    int          m_kill = 0;
    bit          active = 1'b0;
    int          pending = 0;
    logic [24:0] b_addr = 25'd0;
    int          b_seq = -1;
    int          b_trail = 1;
    int          trail_left = -1;
    int          line_beats = 0;
    int          ph = 0;
    logic [23:0] pbg = 24'd0;
    logic [23:0] pmk = 24'd0;
    int          first_eb = -1;
    bit          drop_done = 1'b0;
    int          stale_eb = 0;
    logic [15:0] w;
    logic [15:0] ovr_w [3] = '{16'hAA11, 16'hBB22, 16'hCC33};

    function automatic logic [15:0] gen(input logic [24:0] a);
        return a[15:0] ^ {a[24:16], 7'h55};
    endfunction

    always @(negedge clk) begin
        if (line_seq != m_seq) begin
            m_seq      = line_seq;
            line_beats = 0;
            ph         = 0;
            pbg        = 24'd0;
            pmk        = 24'd0;
            first_eb   = -1;
            drop_done  = 1'b0;
        end
        if (kill_seq != m_kill) begin
            m_kill  = kill_seq;
            active  = 1'b0;
            pending = 0;
        end
        if (sd_end_burst && active && trail_left < 0) begin
            trail_left = b_trail;
            if (b_seq == m_seq && first_eb < 0) first_eb = line_beats - 1;
            if (b_seq != m_seq) stale_eb++;
        end
        if (sd_rd) begin
            pending    = 2;
            active     = 1'b0;
            b_addr     = sd_addr;
            b_seq      = m_seq;
            b_trail    = cfg_trail;
            trail_left = -1;
        end
        sd_data_available = 1'b0;
        if (pending > 0) begin
            pending--;
            if (pending == 0) active = 1'b1;
        end
        if (active) begin
            if (trail_left == 0) begin
                active = 1'b0;
            end else if (b_seq == m_seq && !drop_done && cfg_drop > 0 &&
                         line_beats == cfg_drop) begin
                drop_done = 1'b1;
                active    = 1'b0;
            end else begin
                w = (b_seq == m_seq && cfg_override && line_beats < 3) ? ovr_w[line_beats]
                                                                        : gen(b_addr);
                sd_data_available = 1'b1;
                sd_q   = w;
                b_addr = b_addr + 25'd1;
                if (trail_left > 0) trail_left--;
                if (b_seq == m_seq) begin
                    pbg = {w[7:0], pbg[23:8]};
                    pmk = {w[15:8], pmk[23:8]};
                    line_beats++;
                    if (ph == 2) begin
                        sb_q.push_back({pbg, pmk});
                        ph = 0;
                    end else begin
                        ph++;
                    end
                end
            end
        end
    end

    // Monitor state
    int          mon_seq = 0;
    int          mon_checks = 0;
    int          mon_fail = 0;
    int          wr_cnt = 0;
    int          clr_cnt = 0;
    int          rd_cnt = 0;
    int          rd_total = 0;
    bit          prev_wr = 1'b0;
    bit          got_first = 1'b0;
    logic [23:0] first_bg = 24'd0;
    logic [23:0] first_mk = 24'd0;
    logic [47:0] e;
    logic [24:0] ea;

    always @(negedge clk) begin
        if (fifo_wr) begin
            mon_checks++;
            if (sb_q.size() == 0) begin
                mon_fail++;
                $display("FAIL fifo_wr_unexpected actual=%h/%h required=none", bg_data, mask_data);
            end else begin
                e = sb_q.pop_front();
                if ({bg_data, mask_data} !== e) begin
                    mon_fail++;
                    $display("FAIL pixel actual=%h/%h required=%h/%h", bg_data, mask_data,
                             e[47:24], e[23:0]);
                end
            end
            mon_checks++;
            if (prev_wr) begin
                mon_fail++;
                $display("FAIL fifo_wr_one_cycle actual=2+ cycles required=1 cycle");
            end
            if (!got_first) begin
                got_first = 1'b1;
                first_bg  = bg_data;
                first_mk  = mask_data;
            end
            wr_cnt++;
        end
        prev_wr = fifo_wr;
        if (sd_rd || sd_end_burst) begin
            mon_checks++;
            if (sd_rd && sd_end_burst) begin
                mon_fail++;
                $display("FAIL rd_eb_exclusive actual=both required=one");
            end
        end
        if (sd_rd) begin
            rd_cnt++;
            rd_total++;
            mon_checks++;
            if (rd_exp.size() == 0) begin
                mon_fail++;
                $display("FAIL sd_rd_unexpected actual=%0d required=none", sd_addr);
            end else begin
                ea = rd_exp.pop_front();
                if (sd_addr !== ea) begin
                    mon_fail++;
                    $display("FAIL sd_rd_addr actual=%0d required=%0d", sd_addr, ea);
                end
            end
        end
        if (fifo_clear) clr_cnt++;
        if (line_seq != mon_seq) begin
            mon_seq   = line_seq;
            wr_cnt    = 0;
            clr_cnt   = 0;
            rd_cnt    = 0;
            got_first = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_sd_addr"}, 32'(sd_addr), 32'd0);
        chk({tag, "_sd_rd"}, 32'(sd_rd), 32'd0);
        chk({tag, "_sd_end_burst"}, 32'(sd_end_burst), 32'd0);
        chk({tag, "_fifo_clear"}, 32'(fifo_clear), 32'd0);
        chk({tag, "_fifo_wr"}, 32'(fifo_wr), 32'd0);
        chk({tag, "_bg_data"}, 32'(bg_data), 32'd0);
        chk({tag, "_mask_data"}, 32'(mask_data), 32'd0);
        chk({tag, "_line_done"}, 32'(line_done), 32'd0);
`ifdef LINE_FETCH_STATS_EN
        chk({tag, "_short_lines"}, 32'(short_lines), 32'd0);
        chk({tag, "_bursts_per_line"}, 32'(bursts_per_line), 32'd0);
`endif
    endtask

    task automatic start_line(input int y, input logic [24:0] base, input int drop,
                              input int trail, input bit ovr);
        @(posedge clk);
        #1;
        video_y      = 10'(y);
        cfg_drop     = drop;
        cfg_trail    = trail;
        cfg_override = ovr;
        rd_exp.push_back(base);
        if (drop > 0) rd_exp.push_back(base + 25'(drop));
        line_seq++;
        hblank = 1'b1;
        repeat (3) @(posedge clk);
        #1 hblank = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!line_done && n < 6000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_line_done"}, 32'(line_done), 32'd1);
        repeat (6) @(negedge clk);
    endtask

    task automatic wait_beats(input int target);
        int n = 0;
        while (line_beats < target && n < 6000) begin
            @(posedge clk);
            n++;
        end
        chk("beats_reached", 32'(line_beats >= target), 32'd1);
    endtask

    task automatic check_line(input string tag, input int exp_rd);
        chk({tag, "_fifo_wr_count"}, 32'(wr_cnt), 32'(PPL));
        chk({tag, "_sd_rd_count"}, 32'(rd_cnt), 32'(exp_rd));
        chk({tag, "_fifo_clear_count"}, 32'(clr_cnt), 32'd1);
        chk({tag, "_end_burst_beat"}, 32'(first_eb), 32'(WORDS - 2));
        chk({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
        chk({tag, "_rd_exp_empty"}, 32'(rd_exp.size()), 32'd0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Line A: y=9 -> line 10, override first pixel words
        start_line(9, 25'd21600, 0, 1, 1'b1);
        wait_done("lineA");
        check_line("lineA", 1);
        chk("lineA_first_bg", 32'(first_bg), 32'h332211);
        chk("lineA_first_mask", 32'(first_mk), 32'hCCBBAA);

        // Line B: y=719 wraps to 0; burst broken after 100 words
        start_line(719, 25'd0, 100, 1, 1'b0);
        wait_done("lineB");
        check_line("lineB", 2);

        // Line C: y=800 clamps to 0; aborted after 500 words by line D (y=3 -> 8640)
        start_line(800, 25'd0, 0, 3, 1'b0);
`ifdef LINE_FETCH_STATS_EN
        chk("bursts_per_line_B", 32'(bursts_per_line), 32'd2);
`endif
        wait_beats(500);
        start_line(3, 25'd8640, 0, 1, 1'b0);
`ifdef LINE_FETCH_STATS_EN
        chk("short_lines_after_abort", 32'(short_lines), 32'd1);
        chk("bursts_per_line_C", 32'(bursts_per_line), 32'd1);
`endif
        wait_done("lineD");
        check_line("lineD", 1);
        chk("abort_end_burst_count", 32'(stale_eb), 32'd1);

        // Line E: reset pulse mid-stream
        start_line(20, 25'd45360, 0, 1, 1'b0);
        wait_beats(300);
        @(posedge clk);
        #1;
        kill_seq++;
        reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check_outputs_zero("midreset");
        chk("midreset_sb_empty", 32'(sb_q.size()), 32'd0);
        snap = rd_total;
        repeat (60) @(negedge clk);
        chk("midreset_no_rd", 32'(rd_total), 32'(snap));
        chk("midreset_idle_no_wr", 32'(fifo_wr), 32'd0);

        // Line F: recovery after reset, y=0 -> line 1
        start_line(0, 25'd2160, 0, 1, 1'b0);
        wait_done("lineF");
        check_line("lineF", 1);

        checks   += mon_checks;
        failures += mon_fail;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
